nvm_read_datapath: RTL and testbench

Serial-out datapath of the NVM reader, directly downstream of the read controller. It consumes the controller's `load` and `shift` strobes. On `load` it captures one parallel word from the NVM array at the current `nvm_addr`. On each `shift` it emits one bit MSB-first on `sdo`. After the last bit it flags word completion and advances the read address.

---
 rtl/nvm_read_datapath.sv | 118 +++++++++++
 tb/tb_nvm_read_datapath.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_read_datapath.sv
// Serial-out datapath of the NVM reader: captures a word on load, shifts it out MSB-first on shift.
// Optional even-parity check on each word is built when NVM_PARITY_EN is defined.
module nvm_read_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] nvm_rdata,
    input  logic              nvm_rpar,
    output logic [ADDR_W-1:0] nvm_addr,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              word_done,
    output logic              last_word,
    output logic              busy,
    output logic              parity_err
);
    // state  | meaning
    // IDLE   | no word held; shift strobes are ignored
    // ACTIVE | word loaded, bits remain to be shifted out

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              do_load, do_shift, final_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // load has priority over shift in both states
    always_comb begin
        state_nxt = state;
        do_load   = load;
        do_shift  = 1'b0;
        final_bit = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (!load && shift) begin
                    do_shift  = 1'b1;
                    final_bit = (bit_cnt == CNT_W'(DATA_W - 1));
                    if (final_bit) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            nvm_addr  <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            word_done <= 1'b0;
            last_word <= 1'b0;
        end else begin
            sdo_valid <= 1'b0;
            word_done <= 1'b0;
            last_word <= 1'b0;
            if (do_load) begin
                shreg   <= nvm_rdata;
                bit_cnt <= '0;
            end else if (do_shift) begin
                sdo       <= shreg[DATA_W-1];
                shreg     <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt   <= bit_cnt + CNT_W'(1);
                sdo_valid <= 1'b1;
                if (final_bit) begin
                    word_done <= 1'b1;
                    nvm_addr  <= nvm_addr + ADDR_W'(1);
                    last_word <= (nvm_addr == {ADDR_W{1'b1}});
                end
            end
        end
    end

`ifdef NVM_PARITY_EN
    logic par_cap, par_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_cap    <= 1'b0;
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (do_load) begin
                par_cap <= nvm_rpar;
                par_acc <= 1'b0;
            end else if (do_shift) begin
                par_acc <= par_acc ^ shreg[DATA_W-1];
                if (final_bit)
                    parity_err <= par_acc ^ shreg[DATA_W-1] ^ par_cap;
            end
        end
    end
`else
    logic unused_rpar;
    assign unused_rpar = nvm_rpar;
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_nvm_read_datapath.sv
// Self-checking bench for nvm_read_datapath: word-level reference model plus directed literal checks.
module tb_nvm_read_datapath;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       shift = 1'b0;
    logic [7:0] nvm_rdata = 8'h00;
    logic       nvm_rpar = 1'b0;
    logic [3:0] nvm_addr;
    logic       sdo, sdo_valid, word_done, last_word, busy, parity_err;

    int checks = 0;
    int errors = 0;

    nvm_read_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .shift(shift),
        .nvm_rdata(nvm_rdata), .nvm_rpar(nvm_rpar), .nvm_addr(nvm_addr),
        .sdo(sdo), .sdo_valid(sdo_valid), .word_done(word_done),
        .last_word(last_word), .busy(busy), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level reference: a held word plus how many of its bits have gone out.
    logic [7:0] m_word;
    logic       m_par;
    int         m_idx;
    logic       m_active;
    int         m_addr;
    logic       m_sdo, m_valid, m_done, m_last, m_perr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_addr = 0; m_sdo = 1'b0; m_idx = 0;
            m_valid = 1'b0; m_done = 1'b0; m_last = 1'b0; m_perr = 1'b0;
        end else begin
            m_valid = 1'b0; m_done = 1'b0; m_last = 1'b0; m_perr = 1'b0;
            if (load) begin
                m_word = nvm_rdata; m_par = nvm_rpar; m_idx = 0; m_active = 1'b1;
            end else if (shift && m_active) begin
                m_sdo = m_word[7 - m_idx];
                m_valid = 1'b1;
                m_idx++;
                if (m_idx == 8) begin
                    m_done = 1'b1;
                    m_last = (m_addr == 15);
                    m_addr = (m_addr + 1) % 16;
                    m_active = 1'b0;
`ifdef NVM_PARITY_EN
                    m_perr = (^m_word) ^ m_par;
`endif
                end
            end
        end
    end

    logic [31:0] bits_log;
    int n_valid, n_done, n_last, n_perr, done_at_last;

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, m_active);
            check("nvm_addr", nvm_addr, m_addr);
            check("sdo_valid", sdo_valid, m_valid);
            check("word_done", word_done, m_done);
            check("last_word", last_word, m_last);
            check("parity_err", parity_err, m_perr);
            if (m_valid) check("sdo", sdo, m_sdo);
            if (sdo_valid) begin
                bits_log = {bits_log[30:0], sdo};
                n_valid++;
            end
            if (word_done) n_done++;
            if (parity_err) n_perr++;
            if (last_word) begin
                n_last++;
                done_at_last = n_done;
            end
        end
    end

    task automatic clear_log();
        bits_log = '0; n_valid = 0; n_done = 0; n_last = 0; n_perr = 0; done_at_last = 0;
    endtask

    task automatic step(input logic ld, input logic sh, input logic [7:0] d = 8'h00, input logic p = 1'b0);
        @(negedge clk);
        load = ld; shift = sh; nvm_rdata = d; nvm_rpar = p;
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    task automatic settle();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        #2;
    endtask

    logic exp_perr1;

    initial begin
        clear_log();
        #3;
        check("rst_addr", nvm_addr, 0);
        check("rst_sdo", sdo, 0);
        check("rst_valid", sdo_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", word_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // shifts with nothing loaded
        shifts(5);
        settle();
        check("noload_valid", n_valid, 0);
        check("noload_done", n_done, 0);
        check("noload_addr", nvm_addr, 0);

        // A5 full word
        clear_log();
        step(1'b1, 1'b0, 8'hA5);
        shifts(8);
        settle();
        check("a5_bits", bits_log[7:0], 8'hA5);
        check("a5_nvalid", n_valid, 8);
        check("a5_ndone", n_done, 1);
        check("a5_addr", nvm_addr, 1);
        check("a5_busy", busy, 0);

        // abort FF after 3 bits, reload 3C
        clear_log();
        step(1'b1, 1'b0, 8'hFF);
        shifts(3);
        step(1'b1, 1'b0, 8'h3C);
        shifts(8);
        settle();
        check("reload_bits", bits_log[10:0], 11'h73C);
        check("reload_nvalid", n_valid, 11);
        check("reload_ndone", n_done, 1);
        check("reload_addr", nvm_addr, 2);

        // load and shift together from IDLE
        clear_log();
        step(1'b1, 1'b1, 8'h81);
        step(1'b0, 1'b0);
        #2;
        check("ls_busy", busy, 1);
        check("ls_valid", sdo_valid, 0);
        shifts(8);
        settle();
        check("ls_bits", bits_log[7:0], 8'h81);
        check("ls_nvalid", n_valid, 8);
        check("ls_addr", nvm_addr, 3);

        // parity: A5 has even weight
        exp_perr1 = 1'b0;
`ifdef NVM_PARITY_EN
        exp_perr1 = 1'b1;
`endif
        clear_log();
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        shifts(8);
        settle();
        check("par0_nperr", n_perr, 0);
        clear_log();
        step(1'b1, 1'b0, 8'hA5, 1'b1);
        shifts(8);
        settle();
        check("par1_nperr", n_perr, exp_perr1);
        check("par1_ndone", n_done, 1);

        // 16 back-to-back words from address 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        clear_log();
        for (int w = 0; w < 16; w++) begin
            step(1'b1, 1'b0, 8'(w * 17 + 3), 1'(w & 1));
            shifts(8);
        end
        settle();
        check("b2b_ndone", n_done, 16);
        check("b2b_nlast", n_last, 1);
        check("b2b_last_at", done_at_last, 16);
        check("b2b_addr", nvm_addr, 0);
        check("b2b_nvalid", n_valid, 128);

        // 17th word, asynchronous reset mid-word
        step(1'b1, 1'b0, 8'hE0);
        shifts(3);
        step(1'b0, 1'b0);
        #2;
        check("mid_busy", busy, 1);
        check("mid_sdo", sdo, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sdo", sdo, 0);
        check("arst_valid", sdo_valid, 0);
        check("arst_addr", nvm_addr, 0);
        check("arst_done", word_done, 0);
        check("arst_last", last_word, 0);
        check("arst_perr", parity_err, 0);
        @(negedge clk); rst = 1'b0;

        // resumes at address 0
        clear_log();
        step(1'b1, 1'b0, 8'h69);
        shifts(8);
        settle();
        check("resume_bits", bits_log[7:0], 8'h69);
        check("resume_addr", nvm_addr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
